// File: rtl/timebase_ctrl.sv
// Shared timebase: one prescaler produces a base tick; four channels divide it further.
// A STOP/RUN/PAUSE FSM sequences everything; config writes are retimed onto base-tick boundaries.
module timebase_ctrl #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 1_000,
    parameter int PRE_W   = 16,
    parameter int NCH     = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic           pause,
    input  logic           stop,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_ch,
    input  logic [15:0]    cfg_period,
    output logic           cfg_ready,
    output logic [1:0]     run_state,
    output logic           base_tick,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ch_sq
);

    localparam int               PRE_DIV  = CLK_HZ / BASE_HZ;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic             pending;
    logic [1:0]       pend_ch;
    logic [15:0]      pend_period;
    logic             apply;
    logic             accept;
    logic [15:0]      period [NCH];
    logic [15:0]      ch_cnt [NCH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_STOP;
        else      state <= state_nxt;
    end

    // stop beats pause, pause beats start
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_STOP;
        end else begin
            case (state)
                ST_STOP:  if (start) state_nxt = ST_RUN;
                ST_RUN:   if (pause) state_nxt = ST_PAUSE;
                ST_PAUSE: if (start) state_nxt = ST_RUN;
                default:  state_nxt = ST_STOP;
            endcase
        end
    end

    assign run_state = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= 1'b0;
            if (state == ST_RUN) begin
                if (pre_cnt == PRE_LAST) begin
                    pre_cnt   <= '0;
                    base_tick <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end else if (state == ST_STOP) begin
                pre_cnt <= '0;
            end
        end
    end

    // Config handshake: a write is taken when cfg_we && cfg_ready; one write may be
    // pending at a time and cfg_ready stays low until it has been applied.
    assign cfg_ready = ~pending;
    assign accept    = cfg_we && !pending;
    assign apply     = pending && ((state == ST_STOP) || ((state == ST_RUN) && base_tick));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending     <= 1'b0;
            pend_ch     <= '0;
            pend_period <= '0;
        end else if (apply) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending     <= 1'b1;
            pend_ch     <= cfg_ch;
            pend_period <= cfg_period;
        end
    end

    // An apply replaces that channel's count update for the cycle and restarts its phase.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NCH; i++) begin
                period[i] <= '0;
                ch_cnt[i] <= '0;
            end
            ch_tick <= '0;
            ch_sq   <= '0;
        end else begin
            ch_tick <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (apply && (pend_ch == 2'(i))) begin
                    period[i] <= pend_period;
                    ch_cnt[i] <= '0;
                    ch_sq[i]  <= 1'b0;
                end else if (state == ST_STOP) begin
                    ch_cnt[i] <= '0;
                    ch_sq[i]  <= 1'b0;
                end else if ((state == ST_RUN) && base_tick && (period[i] != 16'd0)) begin
                    if (ch_cnt[i] == period[i] - 16'd1) begin
                        ch_cnt[i]  <= '0;
                        ch_tick[i] <= 1'b1;
                        ch_sq[i]   <= ~ch_sq[i];
                    end else begin
                        ch_cnt[i] <= ch_cnt[i] + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl at PRE_DIV=10: cycle scoreboard plus directed timing checks.
module tb_timebase_ctrl;

    localparam int CLK_HZ  = 20;
    localparam int BASE_HZ = 2;
    localparam int PRE_DIV = 10;
    localparam int W       = 12;

    localparam logic [1:0] M_STOP  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_PAUSE = 2'b10;
    localparam logic [W-1:0] RESET_VEC = {2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000};

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, pause, stop, cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_ready;
    logic [1:0]  run_state;
    logic        base_tick;
    logic [3:0]  ch_tick;
    logic [3:0]  ch_sq;

    timebase_ctrl #(
        .CLK_HZ (CLK_HZ),
        .BASE_HZ(BASE_HZ),
        .PRE_W  (16),
        .NCH    (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_ready (cfg_ready),
        .run_state (run_state),
        .base_tick (base_tick),
        .ch_tick   (ch_tick),
        .ch_sq     (ch_sq)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int bt_count  = 0;
    int ch2_count = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model, advanced on every rising edge
    logic [1:0]  m_state;
    logic [3:0]  m_pre;
    logic        m_bt;
    logic [15:0] m_cnt [4];
    logic [15:0] m_per [4];
    logic [3:0]  m_tick;
    logic [3:0]  m_sq;
    logic        m_pend;
    logic [1:0]  m_pch;
    logic [15:0] m_pper;
    logic        m_apply;
    logic        m_nbt;

    task automatic m_reset();
        m_state = M_STOP;
        m_pre   = '0;
        m_bt    = 1'b0;
        m_tick  = '0;
        m_sq    = '0;
        m_pend  = 1'b0;
        m_pch   = '0;
        m_pper  = '0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = '0;
            m_per[i] = '0;
        end
    endtask

    always @(negedge RST) begin
        m_reset();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            exp_q.push_back(RESET_VEC);
        end
    end

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            m_reset();
        end else begin
            m_apply = m_pend && (m_state == M_STOP || (m_state == M_RUN && m_bt));
            m_tick  = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_apply && m_pch == 2'(i)) begin
                    m_per[i] = m_pper;
                    m_cnt[i] = '0;
                    m_sq[i]  = 1'b0;
                end else if (m_state == M_STOP) begin
                    m_cnt[i] = '0;
                    m_sq[i]  = 1'b0;
                end else if (m_state == M_RUN && m_bt && m_per[i] != 16'd0) begin
                    if (m_cnt[i] + 16'd1 == m_per[i]) begin
                        m_cnt[i]  = '0;
                        m_tick[i] = 1'b1;
                        m_sq[i]   = ~m_sq[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 16'd1;
                    end
                end
            end
            if (m_apply) begin
                m_pend = 1'b0;
            end else if (cfg_we && !m_pend) begin
                m_pend = 1'b1;
                m_pch  = cfg_ch;
                m_pper = cfg_period;
            end
            m_nbt = (m_state == M_RUN) && (m_pre == 4'(PRE_DIV - 1));
            if (m_state == M_RUN)       m_pre = (m_pre == 4'(PRE_DIV - 1)) ? 4'd0 : m_pre + 4'd1;
            else if (m_state == M_STOP) m_pre = 4'd0;
            m_bt = m_nbt;
            if (stop)                              m_state = M_STOP;
            else if (m_state == M_STOP && start)   m_state = M_RUN;
            else if (m_state == M_RUN && pause)    m_state = M_PAUSE;
            else if (m_state == M_PAUSE && start)  m_state = M_RUN;
        end
        exp_q.push_back({m_state, ~m_pend, m_bt, m_tick, m_sq});
    end

    // scoreboard compare and event counters, sampled mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() > 0)
            check("sb", {run_state, cfg_ready, base_tick, ch_tick, ch_sq}, exp_q.pop_front());
        if (base_tick)  bt_count++;
        if (ch_tick[2]) ch2_count++;
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_bt(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (base_tick) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("bt_timeout", 12'd0, 12'd1);
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] per);
        int k;
        k = 0;
        while (!cfg_ready && k < 40) begin
            tick();
            k++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", 12'd0, 12'd1);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   at, at2, s, r1, r2, rdy, tk, b0;
        logic p;
        RST = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        tick(3);
        RST = 1'b1;

        // idle in STOP: no ticks at all
        tick(50);
        check("stop_no_bt", 12'(bt_count), 12'd0);
        check("stop_state", 12'(run_state), 12'(M_STOP));

        cfg_write(2'd0, 16'd1);
        cfg_write(2'd1, 16'd3);
        cfg_write(2'd2, 16'd0);
        cfg_write(2'd3, 16'd4);
        tick(2);
        check("cfg_applied_ready", 12'(cfg_ready), 12'd1);

        // prescaler: first base tick in the 11th RUN cycle, then every 10
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        wait_bt(at);
        check("first_bt", 12'(at - s), 12'd11);
        wait_bt(at2);
        check("bt_spacing", 12'(at2 - at), 12'd10);

        // ch1 period 3 -> square wave period 60 cycles
        r1 = -1; r2 = -1; p = ch_sq[1];
        for (int k = 0; k < 150 && r2 < 0; k++) begin
            @(negedge CLK);
            if (ch_sq[1] && !p) begin
                if (r1 < 0) r1 = cyc;
                else        r2 = cyc;
            end
            p = ch_sq[1];
        end
        check("sq1_period", 12'(r2 - r1), 12'd60);
        tick();

        // retime ch1 to period 2 mid-prescaler; a second write while busy is dropped
        wait_bt(at);
        tick(2);
        cfg_write(2'd1, 16'd2);
        check("cfg_busy", 12'(cfg_ready), 12'd0);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd7;
        tick();
        cfg_we = 1'b0;
        rdy = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (cfg_ready) begin
                rdy = cyc;
                check("retime_sq", 12'(ch_sq[1]), 12'd0);
                break;
            end
        end
        tk = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (ch_tick[1]) begin
                tk = cyc;
                break;
            end
        end
        check("retime_tick", 12'(tk - rdy), 12'd20);
        tick();

        // pause with the prescaler frozen at 6, then resume
        wait_bt(at);
        tick(4);
        pause = 1'b1; tick(); pause = 1'b0;
        b0 = bt_count;
        tick(24);
        check("pause_no_bt", 12'(bt_count - b0), 12'd0);
        check("pause_state", 12'(run_state), 12'(M_PAUSE));
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        wait_bt(at);
        check("resume_bt", 12'(at - (s + 1)), 12'd4);

        // priority among run controls
        start = 1'b1; pause = 1'b1; stop = 1'b1; tick();
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        check("prio_stop", 12'(run_state), 12'(M_STOP));
        start = 1'b1; tick(); start = 1'b0;
        check("restart", 12'(run_state), 12'(M_RUN));
        pause = 1'b1; start = 1'b1; tick(); pause = 1'b0; start = 1'b0;
        check("prio_pause", 12'(run_state), 12'(M_PAUSE));
        start = 1'b1; tick(); start = 1'b0;
        tick(30 + $urandom_range(0, 9));

        // async reset mid-RUN with a config write pending
        cfg_write(2'd3, 16'd9);
        RST = 1'b0;
        #1;
        check("rst_async", 12'({run_state, cfg_ready, base_tick, ch_tick, ch_sq}), RESET_VEC);
        tick(3);
        RST = 1'b1;
        tick(5);
        check("ch2_never", 12'(ch2_count), 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timebase_ctrl.md
Name: timebase_ctrl

Overview:
Shared timebase controller. One prescaler runs from the system oscillator and produces a base tick at BASE_HZ. Four channels each turn that base tick into their own programmable period, giving single-cycle enable pulses and divided square waves. A run-control FSM (STOP/RUN/PAUSE) sequences the whole timebase, and a config port retimes period changes onto base-tick boundaries.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
BASE_HZ, 1_000, base tick rate in Hz; PRE_DIV = CLK_HZ/BASE_HZ, must be >= 2
PRE_W, 16, prescaler counter width; must hold PRE_DIV-1
NCH, 4, channel count (fixed at 4 for this revision)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-low
start  in  1  level; STOP/PAUSE -> RUN
pause  in  1  level; RUN -> PAUSE
stop  in  1  level; any state -> STOP
cfg_we  in  1  config write strobe, accepted when cfg_ready=1
cfg_ch  in  2  channel index for the write
cfg_period  in  16  period in base ticks; 0 = channel disabled
cfg_ready  out  1  high when no config write is pending
run_state  out  2  00 STOP, 01 RUN, 10 PAUSE
base_tick  out  1  one-cycle pulse per prescaler wrap
ch_tick  out  4  one-cycle pulse per channel period
ch_sq  out  4  per-channel square wave; toggles on each ch_tick

Behaviour:
- Reset (RST=0, async):
  - state=STOP; prescaler=0; all ch_cnt=0; all periods=0.
  - base_tick=0, ch_tick=0, ch_sq=0; cfg_ready=1; pending cleared.
- FSM, evaluated each rising edge:
  - stop has priority over pause, and pause over start.
  - STOP: start -> RUN.
  - RUN: stop -> STOP; else pause -> PAUSE.
  - PAUSE: stop -> STOP; else start -> RUN.
  - run_state is the registered state.
- Prescaler:
  - In RUN it counts 0..PRE_DIV-1 and wraps to 0.
  - base_tick is registered and is high the cycle after the prescaler equals PRE_DIV-1.
  - PAUSE freezes the prescaler, ch_cnt and ch_sq; no ticks are emitted.
  - STOP holds the prescaler, ch_cnt and ch_sq at 0; no ticks are emitted.
  - Leaving PAUSE resumes from the frozen value.
- Channels, updated only in cycles where base_tick=1:
  - Period 0: ch_cnt stays 0, no tick.
  - Otherwise, if ch_cnt==period-1: ch_cnt -> 0, ch_tick[i]=1 the next cycle, ch_sq[i] toggles on that same edge.
  - Otherwise ch_cnt increments.
  - Net result: ch_tick lags base_tick by 1 cycle, and ch_sq period = 2*period base ticks.
- Config write:
  - Accepted when cfg_we=1 && cfg_ready=1: latches ch/period into a shadow register; cfg_ready=0 from the next cycle.
  - A write with cfg_ready=0 is ignored and does not disturb the pending value.
- Config apply:
  - Applied on the next base_tick cycle, replacing that channel's count update for that cycle: period loaded, ch_cnt=0, ch_sq[i]=0, no ch_tick.
  - In STOP, applied on the cycle after acceptance.
  - In PAUSE, held pending until RUN resumes and a base_tick occurs.
  - cfg_ready returns to 1 the cycle after apply.
- Other channels are never disturbed by a config apply.
- start/pause/stop are synchronous inputs; synchronising them is the caller's job.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); pending config is discarded.

Test Plan:
- Reset/STOP: assert RST=0 mid-RUN -> run_state=00, ch_tick=0, ch_sq=0, cfg_ready=1 immediately.
  - With CLK_HZ=20, BASE_HZ=2 (PRE_DIV=10): hold start=0 for 50 cycles -> no base_tick.
- Prescaler: PRE_DIV=10, pulse start for 1 cycle -> first base_tick in the 11th RUN cycle, then every 10 cycles; each pulse exactly 1 cycle wide.
- Channel periods:
  - In STOP, write ch0=1, ch1=3, ch2=0; then start.
  - Expect ch_tick[0] one cycle after every base_tick.
  - Expect ch_tick[1] after every 3rd base_tick, with ch_sq[1] period 60 cycles.
  - Expect ch_tick[2] never.
- Config retime: in RUN with ch1=3, write ch1=2 mid-prescaler.
  - cfg_ready=0 until the cycle after the next base_tick.
  - ch1 restarts from 0 with ch_sq[1]=0; the next ch_tick[1] follows 2 base_ticks later.
  - A second write while cfg_ready=0 is ignored.
- Pause/resume: pause with prescaler=6, hold 25 cycles, then start -> no ticks during PAUSE; prescaler resumes at 6; next base_tick 4 cycles after resume.
- Priority: assert start, pause and stop together in RUN -> STOP.
  - Assert pause and start together in RUN -> PAUSE.
